mul_bus_initiator: RTL and testbench

- Bus master on the picorv32 native memory interface that drives the memory-mapped 16x16 multiplier peripheral, in place of the CPU.
- Accepts an operand pair on a valid/ready command port.
- Performs three bus transfers: write A, write B, read product.
- Returns the 32-bit product, or an error flag, on a valid/ready response port.
- Used for hardware self-test of the multiplier and as a non-CPU client of the same address map.

---
 rtl/mul_bus_initiator.sv | 170 +++++++++++++++++
 tb/tb_mul_bus_initiator.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_bus_initiator.sv
// rtl/mul_bus_initiator.sv - picorv32-native bus master driving the 16x16 multiplier peripheral
// Writes A, writes B, reads the product back and returns it (or a timeout error) on a response port.
module mul_bus_initiator #(
  parameter logic [31:0] ADDR_A  = 32'h0FFF_FFF0,
  parameter logic [31:0] ADDR_B  = 32'h0FFF_FFF4,
  parameter logic [31:0] ADDR_R  = 32'h0FFF_FFF8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_product,
  output logic        rsp_error,
  output logic        busy,
  output logic        mem_valid,
  output logic        mem_instr,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, WR_A, GAP_A, WR_B, GAP_B, RD_R, RESP} state_t;

  state_t      state_q, state_d;
  logic [15:0] a_q, a_d, b_q, b_d;
  logic        mem_valid_q, mem_valid_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_product_q, rsp_product_d;
  logic        rsp_error_q, rsp_error_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        busy_q, busy_d;
  logic [31:0] cnt_q, cnt_d;

  logic        xfer_done;
  logic        tmo_hit;
  logic [31:0] cnt_inc;

  assign xfer_done = mem_valid_q && mem_ready;
  assign cnt_inc   = cnt_q + 32'd1;
  // The stalled cycle being evaluated is the one that brings the count up to TIMEOUT.
  assign tmo_hit   = (TIMEOUT != 0) && (cnt_inc == TIMEOUT);

  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    mem_valid_d   = mem_valid_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_wstrb_d   = mem_wstrb_q;
    rsp_product_d = rsp_product_q;
    rsp_error_d   = rsp_error_q;
    cnt_d         = cnt_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          a_d         = cmd_a;
          b_d         = cmd_b;
          state_d     = WR_A;
          mem_valid_d = 1'b1;
          mem_addr_d  = ADDR_A;
          mem_wdata_d = {16'b0, cmd_a};
          mem_wstrb_d = 4'b1111;
          cnt_d       = 32'd0;
        end
      end
      WR_A, WR_B, RD_R: begin
        if (xfer_done) begin
          mem_valid_d = 1'b0;
          if (state_q == WR_A) begin
            state_d = GAP_A;
          end else if (state_q == WR_B) begin
            state_d = GAP_B;
          end else begin
            state_d       = RESP;
            rsp_product_d = mem_rdata;
            rsp_error_d   = 1'b0;
          end
        end else if (tmo_hit) begin
          mem_valid_d   = 1'b0;
          state_d       = RESP;
          rsp_product_d = 32'd0;
          rsp_error_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      GAP_A: begin
        state_d     = WR_B;
        mem_valid_d = 1'b1;
        mem_addr_d  = ADDR_B;
        mem_wdata_d = {16'b0, b_q};
        mem_wstrb_d = 4'b1111;
        cnt_d       = 32'd0;
      end
      GAP_B: begin
        state_d     = RD_R;
        mem_valid_d = 1'b1;
        mem_addr_d  = ADDR_R;
        mem_wdata_d = 32'd0;
        mem_wstrb_d = 4'b0000;
        cnt_d       = 32'd0;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Status outputs are registered copies of the upcoming state.
    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      a_q           <= 16'd0;
      b_q           <= 16'd0;
      mem_valid_q   <= 1'b0;
      mem_addr_q    <= 32'd0;
      mem_wdata_q   <= 32'd0;
      mem_wstrb_q   <= 4'd0;
      rsp_valid_q   <= 1'b0;
      rsp_product_q <= 32'd0;
      rsp_error_q   <= 1'b0;
      cmd_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      cnt_q         <= 32'd0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      mem_valid_q   <= mem_valid_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_wstrb_q   <= mem_wstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_product_q <= rsp_product_d;
      rsp_error_q   <= rsp_error_d;
      cmd_ready_q   <= cmd_ready_d;
      busy_q        <= busy_d;
      cnt_q         <= cnt_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_product = rsp_product_q;
  assign rsp_error   = rsp_error_q;
  assign busy        = busy_q;
  assign mem_valid   = mem_valid_q;
  assign mem_instr   = 1'b0;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_wstrb   = mem_wstrb_q;

endmodule

// File: tb/tb_mul_bus_initiator.sv
// tb/tb_mul_bus_initiator.sv - scoreboard bench for mul_bus_initiator with a multiplier-peripheral responder
module tb_mul_bus_initiator;

  localparam logic [31:0] ADDR_A = 32'h0FFF_FFF0;
  localparam logic [31:0] ADDR_B = 32'h0FFF_FFF4;
  localparam logic [31:0] ADDR_R = 32'h0FFF_FFF8;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_a = 16'd0;
  logic [15:0] cmd_b = 16'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_product;
  logic        rsp_error;
  logic        busy;
  logic        mem_valid;
  logic        mem_instr;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  mul_bus_initiator #(
    .ADDR_A(ADDR_A), .ADDR_B(ADDR_B), .ADDR_R(ADDR_R), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_product(rsp_product), .rsp_error(rsp_error),
    .busy(busy),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] p;
    logic        e;
    int          lat;
  } rsp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } bus_t;

  rsp_t exp_q[$];
  bus_t bus_q[$];
  rsp_t ex;
  bus_t bx;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    nvec++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, expv);
    end
  endtask

  // Multiplier peripheral model: two operand registers, combinational product.
  logic [15:0] pa = 16'd0;
  logic [15:0] pb = 16'd0;
  int          wait_n = 0;
  bit          nack_b = 1'b0;
  int          wcnt = 0;
  int          cyc = 0;
  int          t_acc = 0;

  assign mem_rdata = (mem_addr == ADDR_R) ? ({16'b0, pa} * {16'b0, pb}) : 32'hBAD0_BAD0;

  always @(posedge clk) begin
    cyc++;
    if (!reset && cmd_valid && cmd_ready) t_acc = cyc;
    if (!reset && mem_valid && mem_ready) begin
      if (bus_q.size() == 0) begin
        chk("unexpected_xfer", mem_addr, 32'd0);
      end else begin
        bx = bus_q.pop_front();
        chk("xfer_addr", mem_addr, bx.a);
        chk("xfer_wdata", mem_wdata, bx.d);
        chk("xfer_wstrb", 32'(mem_wstrb), 32'(bx.s));
      end
      if (mem_wstrb == 4'hF && mem_addr == ADDR_A) pa = mem_wdata[15:0];
      if (mem_wstrb == 4'hF && mem_addr == ADDR_B) pb = mem_wdata[15:0];
    end
    if (!reset && mem_valid && !mem_ready) wcnt++;
    else wcnt = 0;
    #1;
    mem_ready = !reset && mem_valid && !(nack_b && mem_addr == ADDR_B) && (wcnt >= wait_n);
  end

  // Monitor: bus protocol and response scoreboard, sampled on the falling edge.
  bit          hv_valid = 1'b0, hv_ready = 1'b0;
  logic [31:0] hv_addr, hv_wdata;
  logic [3:0]  hv_wstrb;
  int          low_run = 0, hi_run = 0, nxfer = 0;
  bit          pr_valid = 1'b0, pr_hs = 1'b0;
  logic [31:0] pr_prod;
  logic        pr_err;

  always @(negedge clk) begin
    if (reset) begin
      hv_valid = 1'b0; hv_ready = 1'b0;
      low_run = 0; hi_run = 0; nxfer = 0;
      pr_valid = 1'b0; pr_hs = 1'b0;
    end else begin
      if (hv_valid && hv_ready) begin
        chk("valid_low_after_xfer", 32'(mem_valid), 32'd0);
        nxfer++;
      end
      if (hv_valid && !hv_ready && mem_valid) begin
        chk("hold_addr", mem_addr, hv_addr);
        chk("hold_wdata", mem_wdata, hv_wdata);
        chk("hold_wstrb", 32'(mem_wstrb), 32'(hv_wstrb));
      end
      if (hv_valid && !hv_ready && !mem_valid) chk("timeout_len", 32'(hi_run), 32'(TMO));
      if (!hv_valid && mem_valid && nxfer > 0) chk("gap_len", 32'(low_run), 32'd1);
      if (!busy) nxfer = 0;
      hi_run  = mem_valid ? hi_run + 1 : 0;
      low_run = mem_valid ? 0 : low_run + 1;
      hv_valid = mem_valid; hv_ready = mem_ready;
      hv_addr = mem_addr; hv_wdata = mem_wdata; hv_wstrb = mem_wstrb;

      // Latency is the index of the first edge at which rsp_valid is sampled high, counted from the accept edge.
      if (rsp_valid && !pr_valid) begin
        if (exp_q.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
        else chk("latency", 32'(cyc - t_acc + 1), 32'(exp_q[0].lat));
      end
      if (rsp_valid && pr_valid && !pr_hs) begin
        chk("rsp_product_stable", rsp_product, pr_prod);
        chk("rsp_error_stable", 32'(rsp_error), 32'(pr_err));
      end
      if (rsp_valid) chk("cmd_ready_in_resp", 32'(cmd_ready), 32'd0);
      pr_hs = rsp_valid && rsp_ready;
      if (pr_hs) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          ex = exp_q.pop_front();
          chk("rsp_product", rsp_product, ex.p);
          chk("rsp_error", 32'(rsp_error), 32'(ex.e));
        end
      end
      pr_valid = rsp_valid; pr_prod = rsp_product; pr_err = rsp_error;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [15:0] a, input logic [15:0] b, input logic [31:0] p,
                          input logic e, input int lat, input bit only_a);
    rsp_t r;
    r.p = p; r.e = e; r.lat = lat;
    exp_q.push_back(r);
    bus_q.push_back('{ADDR_A, {16'b0, a}, 4'hF});
    if (!only_a) begin
      bus_q.push_back('{ADDR_B, {16'b0, b}, 4'hF});
      bus_q.push_back('{ADDR_R, 32'd0, 4'h0});
    end
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [31:0] p,
                      input logic e, input int lat, input bit only_a);
    cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    for (int n = 0; n < 100 && !cmd_ready; n++) step();
    chk("cmd_ready_before_accept", 32'(cmd_ready), 32'd1);
    push_cmd(a, b, p, e, lat, only_a);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 300 && exp_q.size() != 0; n++) step();
    chk("drain", 32'(exp_q.size()), 32'd0);
    step();
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #1 reset = 1'b1;
    step(); step();
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_product", rsp_product, 32'd0);
    chk("rst_rsp_error", 32'(rsp_error), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("mem_instr", 32'(mem_instr), 32'd0);
    reset = 1'b0;
    step();

    // Zero-wait responder.
    wait_n = 0;
    send(16'd3, 16'd5, 32'd15, 1'b0, 6, 1'b0);
    drain();
    send(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0, 6, 1'b0);
    drain();
    send(16'h0000, 16'h1234, 32'd0, 1'b0, 6, 1'b0);
    drain();

    // Three wait cycles per transfer.
    wait_n = 3;
    send(16'd100, 16'd200, 32'd20000, 1'b0, 15, 1'b0);
    drain();

    // ADDR_B never acknowledged: timeout after 8 stalled cycles.
    wait_n = 0;
    nack_b = 1'b1;
    send(16'hABCD, 16'd2, 32'd0, 1'b1, 11, 1'b1);
    drain();
    nack_b = 1'b0;

    // Back-pressured response with a competing command that must be ignored.
    rsp_ready = 1'b0;
    send(16'd2, 16'd21, 32'd42, 1'b0, 6, 1'b0);
    for (int n = 0; n < 100 && !rsp_valid; n++) step();
    chk("rsp_valid_seen", 32'(rsp_valid), 32'd1);
    cmd_a = 16'd7; cmd_b = 16'd9; cmd_valid = 1'b1;
    for (int n = 0; n < 5; n++) begin
      step();
      chk("ignored_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    chk("accept_after_handshake", 32'(cmd_ready), 32'd1);
    push_cmd(16'd7, 16'd9, 32'd63, 1'b0, 6, 1'b0);
    step();
    cmd_valid = 1'b0;
    drain();

    // Asynchronous reset while the product read is outstanding.
    wait_n = 3;
    send(16'd11, 16'd13, 32'd143, 1'b0, 15, 1'b0);
    for (int n = 0; n < 100 && !(mem_valid && mem_addr == ADDR_R); n++) step();
    chk("reached_rd_r", 32'(mem_valid && mem_addr == ADDR_R), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    bus_q.delete();
    step(); step();
    reset = 1'b0;
    #1;
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    step();
    wait_n = 0;
    send(16'd12, 16'd12, 32'd144, 1'b0, 6, 1'b0);
    drain();

    chk("bus_queue_empty", 32'(bus_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
